knn_sequencer: RTL

- Front-end controller for the kNN datapath (distance accumulator, reference-recirculation FIFO, k-sorter).
- Collects one reference vector and replays it contiguously on loadRef.
- Buffers each incoming data point and bursts it in phase with the recirculating reference.
- After the last point it flushes the accumulator pipeline and drives the sorter's done window for k cycles.

---
 rtl/knn_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/knn_sequencer.sv
// Front-end sequencer for the kNN datapath: captures a reference vector, replays it,
// buffers data points and bursts them phase-aligned, then flushes and drives the sorter's done window.
module knn_sequencer #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 32,
  parameter int pointCountWidth    = 16,
  parameter int flushCycles        = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [pointCountWidth-1:0] numPoints,
  input  logic [31:0]                k,
  input  logic                       refValid,
  input  logic [dataWidth-1:0]       refData,
  output logic                       refReady,
  input  logic                       dataValid,
  input  logic [dataWidth-1:0]       dataIn,
  output logic                       dataReady,
  output logic                       loadRef,
  output logic [dataWidth-1:0]       refDataOut,
  output logic [dataWidth-1:0]       dataValueOut,
  output logic [31:0]                dataNameOut,
  output logic                       burstActive,
  output logic                       sortDone,
  output logic                       busy,
  output logic                       finished
);

  localparam int IW = $clog2(numberOfDimensions);
  localparam logic [IW-1:0] LAST_IDX    = IW'(numberOfDimensions - 1);
  localparam logic [31:0]   FLUSH_LAST  = 32'(flushCycles - 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_LOAD_REF   = 4'd1;
  localparam logic [3:0] S_REPLAY     = 4'd2;
  localparam logic [3:0] S_COLLECT    = 4'd3;
  localparam logic [3:0] S_WAIT_PHASE = 4'd4;
  localparam logic [3:0] S_BURST      = 4'd5;
  localparam logic [3:0] S_FLUSH      = 4'd6;
  localparam logic [3:0] S_DRAIN      = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;

  logic [3:0]                 state_q, state_d;
  logic [IW-1:0]              phase_q, phase_d;
  logic [IW-1:0]              ref_idx_q, ref_idx_d;
  logic [IW-1:0]              data_idx_q, data_idx_d;
  logic [pointCountWidth-1:0] num_points_q, num_points_d;
  logic [pointCountWidth-1:0] point_cnt_q, point_cnt_d;
  logic [31:0]                k_q, k_d;
  logic [31:0]                cnt_q, cnt_d;

  logic                 ref_ready_q, ref_ready_d;
  logic                 data_ready_q, data_ready_d;
  logic                 load_ref_q, load_ref_d;
  logic [dataWidth-1:0] ref_data_out_q, ref_data_out_d;
  logic [dataWidth-1:0] data_value_out_q, data_value_out_d;
  logic [31:0]          data_name_out_q, data_name_out_d;
  logic                 burst_active_q, burst_active_d;
  logic                 sort_done_q, sort_done_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;

  logic ref_acc, data_acc;

  logic [dataWidth-1:0] ref_buf [numberOfDimensions];
  logic [dataWidth-1:0] pt_buf  [numberOfDimensions];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    state_d      = state_q;
    ref_idx_d    = ref_idx_q;
    data_idx_d   = data_idx_q;
    num_points_d = num_points_q;
    point_cnt_d  = point_cnt_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    ref_acc      = refValid && ref_ready_q;
    data_acc     = dataValid && data_ready_q;

    // Phase is pinned to 0 until replay starts, then free-runs mod D for the rest of the job.
    if (state_q == S_IDLE || state_q == S_LOAD_REF) phase_d = '0;
    else if (phase_q == LAST_IDX)                   phase_d = '0;
    else                                            phase_d = phase_q + 1'b1;

    if (data_acc) data_idx_d = (data_idx_q == LAST_IDX) ? '0 : data_idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_points_d = numPoints;
          k_d          = k;
          point_cnt_d  = '0;
          ref_idx_d    = '0;
          state_d      = S_LOAD_REF;
        end
      end
      S_LOAD_REF: begin
        if (ref_acc) begin
          if (ref_idx_q == LAST_IDX) begin
            ref_idx_d = '0;
            state_d   = S_REPLAY;
          end else begin
            ref_idx_d = ref_idx_q + 1'b1;
          end
        end
      end
      S_REPLAY: begin
        if (phase_q == LAST_IDX) state_d = (num_points_q != '0) ? S_COLLECT : S_FLUSH;
      end
      S_COLLECT: begin
        if (data_acc && data_idx_q == LAST_IDX) state_d = S_WAIT_PHASE;
      end
      S_WAIT_PHASE: begin
        if (phase_q == LAST_IDX) state_d = S_BURST;
      end
      S_BURST: begin
        if (phase_q == LAST_IDX) begin
          point_cnt_d = point_cnt_q + 1'b1;
          state_d     = (point_cnt_d < num_points_q) ? S_COLLECT : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = (k_q != '0) ? S_DRAIN : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == k_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    ref_ready_d  = (state_d == S_LOAD_REF);
    data_ready_d = (state_d == S_COLLECT) ||
                   (state_d == S_REPLAY && phase_d == LAST_IDX && num_points_q != '0);
    load_ref_d   = (state_d == S_REPLAY);
    ref_data_out_d = load_ref_d ? ref_buf[phase_d] : ref_data_out_q;

    burst_active_d   = (state_d == S_BURST);
    data_value_out_d = burst_active_d ? pt_buf[phase_d] : '0;
    data_name_out_d  = burst_active_d ? 32'(point_cnt_d) : data_name_out_q;

    sort_done_d = (state_d == S_DRAIN);
    busy_d      = (state_d != S_IDLE);
    finished_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      phase_q          <= '0;
      ref_idx_q        <= '0;
      data_idx_q       <= '0;
      num_points_q     <= '0;
      point_cnt_q      <= '0;
      k_q              <= '0;
      cnt_q            <= '0;
      ref_ready_q      <= 1'b0;
      data_ready_q     <= 1'b0;
      load_ref_q       <= 1'b0;
      ref_data_out_q   <= '0;
      data_value_out_q <= '0;
      data_name_out_q  <= '0;
      burst_active_q   <= 1'b0;
      sort_done_q      <= 1'b0;
      busy_q           <= 1'b0;
      finished_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      ref_idx_q        <= ref_idx_d;
      data_idx_q       <= data_idx_d;
      num_points_q     <= num_points_d;
      point_cnt_q      <= point_cnt_d;
      k_q              <= k_d;
      cnt_q            <= cnt_d;
      ref_ready_q      <= ref_ready_d;
      data_ready_q     <= data_ready_d;
      load_ref_q       <= load_ref_d;
      ref_data_out_q   <= ref_data_out_d;
      data_value_out_q <= data_value_out_d;
      data_name_out_q  <= data_name_out_d;
      burst_active_q   <= burst_active_d;
      sort_done_q      <= sort_done_d;
      busy_q           <= busy_d;
      finished_q       <= finished_d;
    end
  end

  // NOTE: buffers carry no reset; every entry is written before it is read in a job.
  always_ff @(posedge clk) begin
    if (ref_acc)  ref_buf[ref_idx_q] <= refData;
    if (data_acc) pt_buf[data_idx_q] <= dataIn;
  end

  assign refReady     = ref_ready_q;
  assign dataReady    = data_ready_q;
  assign loadRef      = load_ref_q;
  assign refDataOut   = ref_data_out_q;
  assign dataValueOut = data_value_out_q;
  assign dataNameOut  = data_name_out_q;
  assign burstActive  = burst_active_q;
  assign sortDone     = sort_done_q;
  assign busy         = busy_q;
  assign finished     = finished_q;

endmodule
